mdu_iterative: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage of the stretched-goal pipelined core.
- Consumes the two register-file read operands and produces a 32-bit result tagged with its destination register, which writeback returns to the register file.
- Radix-2: one partial product or one quotient bit per cycle.
- Fixed latency; the hazard unit stalls decode while the unit is busy.

---
 rtl/mdu_iterative.sv | 159 +++++++++++++++
 tb/tb_mdu_iterative.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - radix-2 iterative RV32M multiply/divide unit
// A single shared 2*DATA_WIDTH accumulator carries either {product_hi, multiplier}
// or {remainder, dividend/quotient}; operands are held as magnitudes and the sign
// is reapplied in FIX, so every operation takes DATA_WIDTH+2 edges.
module mdu_iterative #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  input  logic [ADDRESS_WIDTH-1:0] rd_in,
  input  logic                     flush,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [ADDRESS_WIDTH-1:0] rd_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
  logic [W-1:0]             opnd_q, opnd_d;   // |multiplicand| or |divisor|
  logic [2*W-1:0]           acc_q, acc_d;
  logic                     sa_q, sa_d;       // operand a was negative (signed op)
  logic                     sb_q, sb_d;       // operand b was negative (signed op)
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [W-1:0]             result_q, result_d;
  logic [ADDRESS_WIDTH-1:0] rd_out_q, rd_out_d;

  logic           is_div, signed_a, signed_b, neg_a, neg_b, div0, no_borrow;
  logic [W-1:0]   abs_a, abs_b, quo, rem, fix_val;
  logic [W:0]     mul_sum, rem_shift, diff;
  logic [2*W-1:0] prod;

  // Operand decode, one iteration step, and the FIX-stage sign correction
  always_comb begin
    is_div    = op[2];
    signed_a  = is_div ? ~op[0] : (op == 3'd1 || op == 3'd2);
    signed_b  = is_div ? ~op[0] : (op == 3'd1);
    neg_a     = signed_a & src_a[W-1];
    neg_b     = signed_b & src_b[W-1];
    abs_a     = neg_a ? -src_a : src_a;
    abs_b     = neg_b ? -src_b : src_b;

    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = acc_q[2*W-1:W-1];
    diff      = rem_shift - {1'b0, opnd_q};
    no_borrow = ~diff[W];

    prod      = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo       = acc_q[W-1:0];
    rem       = acc_q[2*W-1:W];
    div0      = (opnd_q == '0);

    if (!op_q[2]) begin
      fix_val = (op_q == 3'd0) ? prod[W-1:0] : prod[2*W-1:W];
    end else if (!op_q[1]) begin
      // a zero divisor yields all-ones regardless of the dividend's sign
      fix_val = ((sa_q ^ sb_q) && !div0) ? -quo : quo;
    end else begin
      fix_val = sa_q ? -rem : rem;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d    = op;
            rd_d    = rd_in;
            sa_d    = neg_a;
            sb_d    = neg_b;
            opnd_d  = is_div ? abs_b : abs_a;
            acc_d   = {{W{1'b0}}, (is_div ? abs_a : abs_b)};
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          if (!op_q[2]) begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end else begin
            acc_d = {(no_borrow ? diff[W-1:0] : rem_shift[W-1:0]), acc_q[W-2:0], no_borrow};
          end
          if (cnt_q == CW'(W - 1)) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_FIX: begin
          result_d = fix_val;
          rd_out_d = rd_q;
          state_d  = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !flush;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed self-checking bench for mdu_iterative
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_assert = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int lat;
  int snap;
  logic bok;

  mdu_iterative #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge (E0), then scramble the operand inputs
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; rd_in = rd;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom; rd_in = 5'($urandom);
  endtask

  // Count cycles after E0 until done is seen; busy must stay high up to it
  task automatic wait_done(output int l, output logic ok);
    l = -1;
    ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) ok = 1'b0;
      if (done === 1'b1) begin
        l = c;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int l;
    logic ok;
    issue(o, a, b, rd);
    wait_done(l, ok);
    check({tag, " latency"}, l, 34);
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    check({tag, " busy_held"}, {31'd0, ok}, 32'd1);
    @(negedge clk);
    check({tag, " done_once"}, {31'd0, done}, 32'd0);
    check({tag, " idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1;
    check("reset busy",   {31'd0, busy}, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul",        3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
    run_op("mulhu",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE);
    run_op("mulh",       3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000);
    run_op("mulhsu",     3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF);
    run_op("div",        3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD);
    run_op("rem",        3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF);
    run_op("divu",       3'd5, 32'd100,      32'd7,        5'd11, 32'd14);
    run_op("remu",       3'd7, 32'd100,      32'd7,        5'd12, 32'd2);
    run_op("divu_by0",   3'd5, 32'h1234,     32'd0,        5'd13, 32'hFFFFFFFF);
    run_op("remu_by0",   3'd7, 32'h1234,     32'd0,        5'd14, 32'h1234);
    run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000);
    run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000);
    run_op("div_neg_by0",3'd4, 32'hFFFFFFF9, 32'd0,        5'd17, 32'hFFFFFFFF);
    run_op("rem_neg_by0",3'd6, 32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFF9);

    // DIV with an ignored start at cycle 10 and a flush at cycle 20
    snap = done_seen;
    issue(3'd4, 32'd1000, 32'd3, 5'd19);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'd11; src_b = 32'd11; rd_in = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush busy_after", {31'd0, busy}, 32'd0);
    check("flush result_kept", result, 32'hFFFFFFF9);
    check("flush rd_kept", {27'd0, rd_out}, 32'd18);
    repeat (40) @(negedge clk);
    check("flush no_done", done_seen, snap);
    check("flush stays_idle", {31'd0, busy}, 32'd0);

    // MUL 3*4 with a stray start mid-CALC that must not disturb it
    issue(3'd0, 32'd3, 32'd4, 5'd21);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'd5; src_a = 32'd99; src_b = 32'd5; rd_in = 5'd22;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bok);
    check("mul34 latency", lat, 24);
    check("mul34 result", result, 32'd12);
    check("mul34 rd_out", {27'd0, rd_out}, 32'd21);

    // Asynchronous reset mid-CALC
    issue(3'd0, 32'd5, 32'd5, 5'd23);
    repeat (10) @(negedge clk);
    snap = done_seen;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset busy", {31'd0, busy}, 32'd0);
    check("areset done", {31'd0, done}, 32'd0);
    check("areset result", result, 32'd0);
    check("areset rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("areset no_done", done_seen, snap);

    // Start held through DONE (ignored) into the first IDLE cycle (accepted)
    issue(3'd0, 32'd5, 32'd6, 5'd3);
    wait_done(lat, bok);
    check("b2b first latency", lat, 34);
    check("b2b first result", result, 32'd30);
    start = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9; rd_in = 5'd4;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    wait_done(lat, bok);
    check("b2b second latency", lat, 34);
    check("b2b second result", result, 32'd81);
    check("b2b second rd_out", {27'd0, rd_out}, 32'd4);
    check("b2b busy_held", {31'd0, bok}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
